// File: rtl/decode_dispatch_stage_if.sv
// Handshake and data bundle for decode_dispatch_stage.
//   slave  : the stage itself (fetch in, register-file read, issue out, writeback in)
//   master : the environment around the stage (fetch, register file, ALU cluster, writeback)
// Signal groups:
//   fetch     : iINSTR_VALID / oINSTR_READY / iINSTR
//   regfile   : oRS1 / oRS2 addresses out, iRS1_DATA / iRS2_DATA back (same cycle)
//   issue     : oISSUE_VALID / iISSUE_READY plus oFMT/oOPCODE/oRD/oALU_IN1/oALU_IN2/oIMM/oILLEGAL
//   writeback : iWB_VALID / iWB_RD / iWB_DATA
interface decode_dispatch_stage_if #(
  parameter int XLEN = 32
);
  logic            iINSTR_VALID;
  logic            oINSTR_READY;
  logic [31:0]     iINSTR;
  logic [4:0]      oRS1;
  logic [4:0]      oRS2;
  logic [XLEN-1:0] iRS1_DATA;
  logic [XLEN-1:0] iRS2_DATA;
  logic            oISSUE_VALID;
  logic            iISSUE_READY;
  logic [5:0]      oFMT;
  logic [6:0]      oOPCODE;
  logic [4:0]      oRD;
  logic [XLEN-1:0] oALU_IN1;
  logic [XLEN-1:0] oALU_IN2;
  logic [XLEN-1:0] oIMM;
  logic            oILLEGAL;
  logic            iWB_VALID;
  logic [4:0]      iWB_RD;
  logic [XLEN-1:0] iWB_DATA;

  modport slave (
    input  iINSTR_VALID, iINSTR, iRS1_DATA, iRS2_DATA, iISSUE_READY,
           iWB_VALID, iWB_RD, iWB_DATA,
    output oINSTR_READY, oRS1, oRS2, oISSUE_VALID, oFMT, oOPCODE, oRD,
           oALU_IN1, oALU_IN2, oIMM, oILLEGAL
  );

  modport master (
    output iINSTR_VALID, iINSTR, iRS1_DATA, iRS2_DATA, iISSUE_READY,
           iWB_VALID, iWB_RD, iWB_DATA,
    input  oINSTR_READY, oRS1, oRS2, oISSUE_VALID, oFMT, oOPCODE, oRD,
           oALU_IN1, oALU_IN2, oIMM, oILLEGAL
  );
endinterface

// File: rtl/decode_dispatch_stage.sv
// decode_dispatch_stage: buffers fetched instructions in a small FIFO, decodes
// the head (R/I/S/B/U/J), reads the register file combinationally and issues
// into a registered slot with valid/ready. A busy-register scoreboard, set on
// issue and cleared by writeback, blocks RAW/WAW hazards.
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    decode_dispatch_stage_if.slave (fetch, regfile read, issue, writeback)
// Build option:
//   SCOREBOARD_BYPASS_EN  when defined, a same-cycle writeback clears the hazard
//                         and its data is forwarded into the issued operands.
//                         When undefined, iWB_DATA is ignored.
module decode_dispatch_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input logic                   CLK,
  input logic                   RST_N,
  decode_dispatch_stage_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_J    = 7'b1101111;

  // ---------------- FIFO ----------------
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          rstDone;   // holds ready low until the first edge after release
  logic          push, pop, headValid;
  logic [31:0]   head;

  assign headValid        = (count != '0);
  assign head             = mem[rdPtr];
  assign bus.oINSTR_READY = rstDone & (count != FULL);
  assign push             = bus.iINSTR_VALID & bus.oINSTR_READY;

  always_ff @(posedge CLK) begin
    if (push) mem[wrPtr] <= bus.iINSTR;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rstDone <= 1'b0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
    end else begin
      rstDone <= 1'b1;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- head decode ----------------
  logic [6:0]        op;
  logic              fR, fI, fS, fB, fU, fJ, illegal, writesRd;
  logic [5:0]        fmt;
  logic [4:0]        rd, rs1, rs2;
  logic signed [31:0] immRaw;
  logic [XLEN-1:0]   imm;

  always_comb begin
    op       = head[6:0];
    // Flags are qualified by headValid so an empty FIFO decodes to all zeros.
    fR       = headValid & (op == OP_R);
    fI       = headValid & ((op == OP_IMM) | (op == OP_LOAD) | (op == OP_JALR));
    fS       = headValid & (op == OP_S);
    fB       = headValid & (op == OP_B);
    fU       = headValid & ((op == OP_LUI) | (op == OP_AUI));
    fJ       = headValid & (op == OP_J);
    fmt      = {fJ, fU, fB, fS, fI, fR};
    illegal  = headValid & ~(|fmt);
    writesRd = fR | fI | fU | fJ;
    // Illegal opcodes zero every register field, so they never touch the
    // scoreboard and never stall.
    rd       = writesRd          ? head[11:7]  : 5'd0;
    rs1      = (fR | fI | fS | fB) ? head[19:15] : 5'd0;
    rs2      = (fR | fS | fB)      ? head[24:20] : 5'd0;

    immRaw = '0;
    unique case (1'b1)
      fI:      immRaw = {{20{head[31]}}, head[31:20]};
      fS:      immRaw = {{20{head[31]}}, head[31:25], head[11:7]};
      fB:      immRaw = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      fU:      immRaw = {head[31:12], 12'b0};
      fJ:      immRaw = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      default: immRaw = '0;
    endcase
    imm = XLEN'(immRaw);
  end

  assign bus.oRS1 = rs1;
  assign bus.oRS2 = rs2;

  // ---------------- hazard / operands ----------------
  logic [NREG-1:0] busy;
  logic [31:0]     busyEff;
  logic            stall, issue;
  logic [XLEN-1:0] in1, in2;

  always_comb begin
    busyEff = 32'(busy);
`ifdef SCOREBOARD_BYPASS_EN
    // A writeback landing this cycle already satisfies the dependency.
    if (bus.iWB_VALID) busyEff[bus.iWB_RD] = 1'b0;
    in1 = (bus.iWB_VALID && rs1 != 5'd0 && rs1 == bus.iWB_RD) ? bus.iWB_DATA : bus.iRS1_DATA;
    in2 = (bus.iWB_VALID && rs2 != 5'd0 && rs2 == bus.iWB_RD) ? bus.iWB_DATA : bus.iRS2_DATA;
`else
    in1 = bus.iRS1_DATA;
    in2 = bus.iRS2_DATA;
`endif
    busyEff[0] = 1'b0;
    if (!(fR | fI | fS | fB)) in1 = '0;
    if (!(fR | fS | fB))      in2 = '0;
    stall = busyEff[rs1] | busyEff[rs2] | (writesRd & busyEff[rd]);
    issue = headValid & ~stall & (~bus.oISSUE_VALID | bus.iISSUE_READY);
  end

  assign pop = issue;

  // ---------------- scoreboard ----------------
  logic [31:0] sbNext;

  always_comb begin
    sbNext = 32'(busy);
    // Clear before set: with bypass a WAW on the writeback register must
    // leave the new writer marked busy.
    if (bus.iWB_VALID) sbNext[bus.iWB_RD] = 1'b0;
    if (issue && writesRd && rd != 5'd0) sbNext[rd] = 1'b1;
    sbNext[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) busy <= '0;
    else        busy <= sbNext[NREG-1:0];
  end

  // ---------------- issue slot ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.oISSUE_VALID <= 1'b0;
      bus.oFMT         <= '0;
      bus.oOPCODE      <= '0;
      bus.oRD          <= '0;
      bus.oALU_IN1     <= '0;
      bus.oALU_IN2     <= '0;
      bus.oIMM         <= '0;
      bus.oILLEGAL     <= 1'b0;
    end else if (issue) begin
      bus.oISSUE_VALID <= 1'b1;
      bus.oFMT         <= fmt;
      bus.oOPCODE      <= op;
      bus.oRD          <= rd;
      bus.oALU_IN1     <= in1;
      bus.oALU_IN2     <= in2;
      bus.oIMM         <= imm;
      bus.oILLEGAL     <= illegal;
    end else if (bus.iISSUE_READY) begin
      bus.oISSUE_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_dispatch_stage.sv
module tb_decode_dispatch_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  decode_dispatch_stage_if #(.XLEN(32)) bus ();

  decode_dispatch_stage #(.XLEN(32), .DEPTH(2), .NREG(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // push one instruction, then one more edge so it lands in the issue slot
  task automatic pushOne(input logic [31:0] ins);
    bus.iINSTR_VALID = 1'b1;
    bus.iINSTR       = ins;
    step();
    bus.iINSTR_VALID = 1'b0;
    step();
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.iINSTR_VALID = 1'b0;
    bus.iINSTR       = '0;
    bus.iRS1_DATA    = '0;
    bus.iRS2_DATA    = '0;
    bus.iISSUE_READY = 1'b0;
    bus.iWB_VALID    = 1'b0;
    bus.iWB_RD       = '0;
    bus.iWB_DATA     = '0;

    // reset state
    #12;
    chk("rst_ready", bus.oINSTR_READY, 0);
    chk("rst_valid", bus.oISSUE_VALID, 0);
    chk("rst_rs1", bus.oRS1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel_ready_low", bus.oINSTR_READY, 0);
    step();
    chk("rel_ready_high", bus.oINSTR_READY, 1);

    // ADD x3,x1,x2
    bus.iINSTR_VALID = 1'b1;
    bus.iINSTR       = 32'h002081B3;
    bus.iRS1_DATA    = 32'd5;
    bus.iRS2_DATA    = 32'd7;
    bus.iISSUE_READY = 1'b1;
    step();
    chk("add_head_rs1", bus.oRS1, 1);
    chk("add_head_rs2", bus.oRS2, 2);
    chk("add_not_yet", bus.oISSUE_VALID, 0);
    // ADDI x4,x3,1 right behind it
    bus.iINSTR = 32'h00118213;
    step();
    bus.iINSTR_VALID = 1'b0;
    chk("add_valid", bus.oISSUE_VALID, 1);
    chk("add_fmt", bus.oFMT, 6'b000001);
    chk("add_op", bus.oOPCODE, 7'h33);
    chk("add_rd", bus.oRD, 3);
    chk("add_in1", bus.oALU_IN1, 5);
    chk("add_in2", bus.oALU_IN2, 7);
    chk("add_imm", bus.oIMM, 0);
    chk("add_ill", bus.oILLEGAL, 0);
    chk("addi_head_rs1", bus.oRS1, 3);
    step();
    chk("raw_stall1", bus.oISSUE_VALID, 0);
    step();
    chk("raw_stall2", bus.oISSUE_VALID, 0);
    bus.iWB_VALID = 1'b1;
    bus.iWB_RD    = 5'd3;
    bus.iWB_DATA  = 32'h99;
    bus.iRS1_DATA = 32'h11;
    step();
    bus.iWB_VALID = 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    chk("byp_valid", bus.oISSUE_VALID, 1);
    chk("byp_in1", bus.oALU_IN1, 32'h99);
    chk("byp_imm", bus.oIMM, 1);
    chk("byp_rd", bus.oRD, 4);
    step();
    chk("byp_release", bus.oISSUE_VALID, 0);
`else
    chk("wb_edge_stall", bus.oISSUE_VALID, 0);
    step();
    chk("addi_valid", bus.oISSUE_VALID, 1);
    chk("addi_fmt", bus.oFMT, 6'b000010);
    chk("addi_rd", bus.oRD, 4);
    chk("addi_in1", bus.oALU_IN1, 32'h11);
    chk("addi_in2", bus.oALU_IN2, 0);
    chk("addi_imm", bus.oIMM, 1);
`endif
    bus.iWB_VALID = 1'b1;
    bus.iWB_RD    = 5'd4;
    step();
    bus.iWB_VALID = 1'b0;

    // backpressure: slot holds first, FIFO fills, extra push refused
    bus.iISSUE_READY = 1'b0;
    bus.iINSTR_VALID = 1'b1;
    bus.iINSTR       = 32'h00100313;   // ADDI x6,x0,1
    step();
    bus.iINSTR       = 32'h00200393;   // ADDI x7,x0,2
    step();
    bus.iINSTR       = 32'h00300413;   // ADDI x8,x0,3
    step();
    chk("bp_full_ready", bus.oINSTR_READY, 0);
    chk("bp_valid", bus.oISSUE_VALID, 1);
    chk("bp_rd6", bus.oRD, 6);
    bus.iINSTR       = 32'h00400493;   // ADDI x9,x0,4 -- must be refused
    step();
    bus.iINSTR_VALID = 1'b0;
    chk("bp_hold_rd", bus.oRD, 6);
    chk("bp_hold_imm", bus.oIMM, 1);
    chk("bp_still_full", bus.oINSTR_READY, 0);
    bus.iISSUE_READY = 1'b1;
    step();
    chk("drain_rd7", bus.oRD, 7);
    chk("drain_imm2", bus.oIMM, 2);
    step();
    chk("drain_rd8", bus.oRD, 8);
    chk("drain_imm3", bus.oIMM, 3);
    step();
    chk("drain_empty", bus.oISSUE_VALID, 0);
    for (int r = 6; r <= 8; r++) begin
      bus.iWB_VALID = 1'b1;
      bus.iWB_RD    = 5'(r);
      step();
    end
    bus.iWB_VALID = 1'b0;

    // LUI x5,0x12345
    bus.iINSTR_VALID = 1'b1;
    bus.iINSTR       = 32'h123452B7;
    step();
    bus.iINSTR_VALID = 1'b0;
    chk("lui_head_rs1", bus.oRS1, 0);
    chk("lui_head_rs2", bus.oRS2, 0);
    step();
    chk("lui_valid", bus.oISSUE_VALID, 1);
    chk("lui_fmt", bus.oFMT, 6'b010000);
    chk("lui_imm", bus.oIMM, 32'h12345000);
    chk("lui_in1", bus.oALU_IN1, 0);
    chk("lui_in2", bus.oALU_IN2, 0);
    chk("lui_rd", bus.oRD, 5);

    // illegal opcode
    pushOne(32'h0000007F);
    chk("ill_valid", bus.oISSUE_VALID, 1);
    chk("ill_flag", bus.oILLEGAL, 1);
    chk("ill_fmt", bus.oFMT, 0);
    chk("ill_imm", bus.oIMM, 0);

    // BEQ x0,x0,-8
    pushOne(32'hFE000CE3);
    chk("b_fmt", bus.oFMT, 6'b001000);
    chk("b_imm", bus.oIMM, 32'hFFFFFFF8);
    chk("b_rd", bus.oRD, 0);
    chk("b_ill", bus.oILLEGAL, 0);

    // SW x2,8(x1)
    bus.iRS1_DATA = 32'h11;
    bus.iRS2_DATA = 32'h22;
    pushOne(32'h0020A423);
    chk("s_fmt", bus.oFMT, 6'b000100);
    chk("s_imm", bus.oIMM, 8);
    chk("s_rd", bus.oRD, 0);
    chk("s_in1", bus.oALU_IN1, 32'h11);
    chk("s_in2", bus.oALU_IN2, 32'h22);

    // x5 is still busy from the LUI: two dependents fill the FIFO, then reset
    bus.iINSTR_VALID = 1'b1;
    bus.iINSTR       = 32'h00128493;   // ADDI x9,x5,1
    step();
    bus.iINSTR       = 32'h00100513;   // ADDI x10,x0,1
    step();
    bus.iINSTR_VALID = 1'b0;
    chk("stall_full", bus.oINSTR_READY, 0);
    chk("stall_valid", bus.oISSUE_VALID, 0);
    chk("stall_rs1", bus.oRS1, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rs1", bus.oRS1, 0);
    chk("mid_rst_ready", bus.oINSTR_READY, 0);
    chk("mid_rst_valid", bus.oISSUE_VALID, 0);
    chk("mid_rst_fmt", bus.oFMT, 0);
    chk("mid_rst_in1", bus.oALU_IN1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_ready", bus.oINSTR_READY, 1);
    chk("post_rst_valid", bus.oISSUE_VALID, 0);
    chk("post_rst_rs1", bus.oRS1, 0);
    pushOne(32'h00128593);             // ADDI x11,x5,1 -- x5 no longer busy
    chk("post_rst_issue", bus.oISSUE_VALID, 1);
    chk("post_rst_rd", bus.oRD, 11);
    chk("post_rst_in1", bus.oALU_IN1, 32'h11);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
